// File: rtl/rs_timer_pkg.sv
// Shared types for the timer bank: the per-channel counting mode.
package rs_timer_pkg;

   typedef enum logic [1:0] {
      MODE_FREE    = 2'b00,
      MODE_RELOAD  = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

endpackage

// File: rtl/rs_timer_chan.sv
// One timer channel: counter, run status, sticky wrap flag and compare pulse.
// Advances on the shared prescaler tick; clr > load > step priority.
module rs_timer_chan
   import rs_timer_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  i_tick,
   input  logic                  i_en,
   input  logic                  i_down,
   input  logic [1:0]            i_mode,
   input  logic [DATA_WIDTH-1:0] i_delta,
   input  logic [DATA_WIDTH-1:0] i_reload,
   input  logic [DATA_WIDTH-1:0] i_cmp,
   input  logic                  i_clr,
   input  logic                  i_load,
   input  logic                  i_flag_clr,
   output logic [DATA_WIDTH-1:0] o_dat,
   output logic                  o_ovf,
   output logic                  o_cmp,
   output logic                  o_run
);

   logic [DATA_WIDTH-1:0] r_cnt;
   logic                  r_run;
   logic                  r_ovf;
   logic                  r_cmp;

   mode_e                 w_mode;
   logic [DATA_WIDTH:0]   w_sum;
   logic                  w_wrap;
   logic                  w_step;
   logic [DATA_WIDTH-1:0] w_cnt_d;
   logic                  w_run_d;
   logic                  w_upd;
   logic                  w_wrap_ev;

   assign w_mode = mode_e'(i_mode);

   // The extra MSB is the carry when counting up and the borrow when counting down.
   assign w_sum  = i_down ? ({1'b0, r_cnt} - {1'b0, i_delta})
                          : ({1'b0, r_cnt} + {1'b0, i_delta});
   assign w_wrap = w_sum[DATA_WIDTH];
   assign w_step = i_tick & i_en & r_run & (i_delta != '0);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_cnt_d   = r_cnt;
      w_run_d   = r_run;
      w_upd     = 1'b0;
      w_wrap_ev = 1'b0;
      if (i_clr) begin
         w_cnt_d = '0;
         w_run_d = 1'b1;
         w_upd   = 1'b1;
      end else if (i_load) begin
         w_cnt_d = i_reload;
         w_run_d = 1'b1;
         w_upd   = 1'b1;
      end else if (w_step) begin
         w_upd     = 1'b1;
         w_wrap_ev = w_wrap;
         case (w_mode)
            MODE_RELOAD: w_cnt_d = w_wrap ? i_reload : w_sum[DATA_WIDTH-1:0];
            MODE_ONESHOT: begin
               w_cnt_d = w_wrap ? i_reload : w_sum[DATA_WIDTH-1:0];
               if (w_wrap) w_run_d = 1'b0;
            end
            default: w_cnt_d = w_sum[DATA_WIDTH-1:0];
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= '0;
         r_run <= 1'b1;
         r_ovf <= 1'b0;
         r_cmp <= 1'b0;
      end else begin
         r_cnt <= w_cnt_d;
         r_run <= w_run_d;
         r_cmp <= w_upd & (w_cnt_d == i_cmp);
         r_ovf <= w_wrap_ev | (r_ovf & ~i_flag_clr);
      end
   end

   assign o_dat = r_cnt;
   assign o_ovf = r_ovf;
   assign o_cmp = r_cmp;
   assign o_run = r_run;

endmodule

// File: rtl/rs_timer_bank.sv
// Bank of independent timer channels behind one free-running prescaler.
// Packed configuration ports are sliced per channel here.
module rs_timer_bank
   import rs_timer_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 16,
   parameter int PSC_WIDTH  = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [PSC_WIDTH-1:0]           psc_i,
   input  logic [NUM_CH-1:0]              en_i,
   input  logic [NUM_CH-1:0]              down_i,
   input  logic [2*NUM_CH-1:0]            mode_i,
   input  logic [DATA_WIDTH*NUM_CH-1:0]   delta_i,
   input  logic [DATA_WIDTH*NUM_CH-1:0]   reload_i,
   input  logic [DATA_WIDTH*NUM_CH-1:0]   cmp_i,
   input  logic [NUM_CH-1:0]              clr_i,
   input  logic [NUM_CH-1:0]              load_i,
   input  logic [NUM_CH-1:0]              flag_clr_i,
   output logic [DATA_WIDTH*NUM_CH-1:0]   dat_o,
   output logic [NUM_CH-1:0]              ovf_o,
   output logic [NUM_CH-1:0]              cmp_o,
   output logic [NUM_CH-1:0]              run_o
);

   logic [PSC_WIDTH-1:0] r_psc_cnt;
   logic                 w_tick;

   // >= rather than == so lowering psc_i below the running count ticks on the next cycle.
   assign w_tick = (r_psc_cnt >= psc_i);

   always_ff @(posedge clk_i) begin
      if (rst_i)       r_psc_cnt <= '0;
      else if (w_tick) r_psc_cnt <= '0;
      else             r_psc_cnt <= r_psc_cnt + 1'b1;
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
      rs_timer_chan #(
         .DATA_WIDTH(DATA_WIDTH)
      ) u_chan (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .i_tick     (w_tick),
         .i_en       (en_i[k]),
         .i_down     (down_i[k]),
         .i_mode     (mode_i[2*k +: 2]),
         .i_delta    (delta_i[DATA_WIDTH*k +: DATA_WIDTH]),
         .i_reload   (reload_i[DATA_WIDTH*k +: DATA_WIDTH]),
         .i_cmp      (cmp_i[DATA_WIDTH*k +: DATA_WIDTH]),
         .i_clr      (clr_i[k]),
         .i_load     (load_i[k]),
         .i_flag_clr (flag_clr_i[k]),
         .o_dat      (dat_o[DATA_WIDTH*k +: DATA_WIDTH]),
         .o_ovf      (ovf_o[k]),
         .o_cmp      (cmp_o[k]),
         .o_run      (run_o[k])
      );
   end

endmodule
